booth_r4_seq_mul: RTL and testbench

Parametrised sequential radix-4 Booth multiplier with valid/ready handshakes on both sides. Supports signed and unsigned operands, selected per operation. It retires one Booth digit per clock and holds the result until the consumer accepts it. It is the drop-in successor to the fixed 32-bit Booth multiplier in the radix_4 deliverable, for use inside the multiplier comparison datapath.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_r4_digit_enc.sv | 47 ++++
 rtl/booth_r4_seq_mul.sv | 118 +++++++++++
 tb/tb_booth_r4_seq_mul.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } digit_sel_t;

   // One extra digit beyond WIDTH/2 covers the zero-extended top of an unsigned multiplier.
   function automatic int digit_count(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: maps a multiplier triplet to a digit select and partial product.
module booth_r4_digit_enc
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]              triplet,
   input  logic [WIDTH+1:0]        mcand,
   output digit_sel_t              sel,
   output logic signed [WIDTH+2:0] pp
);

   localparam logic [WIDTH+2:0] ONE = {{(WIDTH+2){1'b0}}, 1'b1};

   logic [WIDTH+2:0] mcand_x1;
   logic [WIDTH+2:0] mcand_x2;

   assign mcand_x1 = {mcand[WIDTH+1], mcand};
   assign mcand_x2 = {mcand, 1'b0};

   // Decode the overlapping triplet into one of the five Booth digits.
   always_comb begin
      sel = ZERO;
      case (triplet)
         3'b000, 3'b111: sel = ZERO;
         3'b001, 3'b010: sel = POS1;
         3'b011:         sel = POS2;
         3'b100:         sel = NEG2;
         3'b101, 3'b110: sel = NEG1;
         default:        sel = ZERO;
      endcase
   end

   // Build the partial product; negation as ~x+1 keeps the most-negative operand exact.
   always_comb begin
      pp = '0;
      case (sel)
         ZERO:    pp = '0;
         POS1:    pp = mcand_x1;
         POS2:    pp = mcand_x2;
         NEG1:    pp = ~mcand_x1 + ONE;
         NEG2:    pp = ~mcand_x2 + ONE;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_r4_seq_mul
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int N  = digit_count(WIDTH);
   localparam int CW = $clog2(N + 1);
   localparam int AW = 2 * WIDTH + 4;

   state_t                state;
   state_t                next_state;

   logic [WIDTH+1:0]      mcand;
   logic [WIDTH+2:0]      mplier;
   logic [AW-1:0]         acc;
   logic [CW-1:0]         cnt;
   logic [2*WIDTH-1:0]    product_q;

   logic [WIDTH+1:0]      ext_a;
   logic [WIDTH+1:0]      ext_b;
   logic                  last_digit;

   digit_sel_t            sel;
   logic signed [WIDTH+2:0] pp;
   logic [AW-1:0]         pp_ext;
   logic [AW-1:0]         pp_shifted;
   logic [AW-1:0]         acc_next;

   assign ext_a      = {{2{is_signed & a[WIDTH-1]}}, a};
   assign ext_b      = {{2{is_signed & b[WIDTH-1]}}, b};
   assign last_digit = (cnt == CW'(N - 1));

   // The multiplier register shifts right two bits per digit, so the current triplet is always its low bits.
   booth_r4_digit_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .triplet (mplier[2:0]),
      .mcand   (mcand),
      .sel     (sel),
      .pp      (pp)
   );

   // Align the partial product to its digit weight and skip the add for zero digits.
   always_comb begin
      pp_ext     = {{(AW - WIDTH - 3){pp[WIDTH+2]}}, pp};
      pp_shifted = pp_ext << {cnt, 1'b0};
      acc_next   = (sel == ZERO) ? acc : acc + pp_shifted;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: accept in IDLE, walk the digits in RUN, wait for the consumer in DONE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = RUN;
         RUN:     if (last_digit) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Operand capture, digit iteration and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            mcand  <= ext_a;
            mplier <= {ext_b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            acc    <= acc_next;
            mplier <= mplier >> 2;
            cnt    <= cnt + CW'(1);
            if (last_digit) begin
               product_q <= acc_next[2*WIDTH-1:0];
            end
         end
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed and reference-model checks for booth_r4_seq_mul at WIDTH=32 and WIDTH=8.
module tb_booth_r4_seq_mul;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        vs;
      logic [63:0] vexp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        is_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] product;
   logic        busy;

   logic        in_valid_8 = 1'b0;
   logic        in_ready_8;
   logic [7:0]  a_8 = '0;
   logic [7:0]  b_8 = '0;
   logic        is_signed_8 = 1'b0;
   logic        out_valid_8;
   logic        out_ready_8 = 1'b0;
   logic [15:0] product_8;
   logic        busy_8;

   int checks = 0;
   int failures = 0;

   vec_t vecs [13];

   booth_r4_seq_mul #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   booth_r4_seq_mul #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_8),
      .in_ready  (in_ready_8),
      .a         (a_8),
      .b         (b_8),
      .is_signed (is_signed_8),
      .out_valid (out_valid_8),
      .out_ready (out_ready_8),
      .product   (product_8),
      .busy      (busy_8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One full 32-bit operation: accept, count latency, optional stall, optional interfering inputs, handoff.
   task automatic run32(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input logic [63:0] vexp, input int stall, input bit interfere);
      int lat;
      logic [63:0] held;
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'(1));
      in_valid  = 1'b1;
      a         = va;
      b         = vb;
      is_signed = vs;
      @(posedge clk);
      #1;
      check("busy_run", 64'(busy), 64'(1));
      check("in_ready_run", 64'(in_ready), 64'(0));
      if (interfere) begin
         a         = ~va;
         b         = vb + 32'd1;
         is_signed = ~vs;
      end else begin
         in_valid = 1'b0;
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
      end
      in_valid = 1'b0;
      check("latency32", 64'(lat), 64'(17));
      check("product32", product, vexp);
      held = product;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid32", 64'(out_valid), 64'(1));
         check("hold_product32", product, held);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after32", 64'(in_ready), 64'(1));
      check("out_valid_after32", 64'(out_valid), 64'(0));
      check("busy_after32", 64'(busy), 64'(0));
   endtask

   // One 8-bit operation against an independent arithmetic model, with a random output stall.
   task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vs);
      int lat;
      int stall;
      logic [15:0] exp;
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic [15:0] held;
      sa = $signed({{8{va[7]}}, va});
      sb = $signed({{8{vb[7]}}, vb});
      if (vs) exp = 16'(sa * sb);
      else    exp = {8'd0, va} * {8'd0, vb};
      @(negedge clk);
      in_valid_8  = 1'b1;
      a_8         = va;
      b_8         = vb;
      is_signed_8 = vs;
      @(posedge clk);
      #1;
      in_valid_8 = 1'b0;
      lat = 0;
      while (!out_valid_8 && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check("latency8", 64'(lat), 64'(5));
      check("product8", 64'(product_8), 64'(exp));
      if (product_8 !== exp) begin
         $display("[TB] operands a=%h b=%h signed=%0d", va, vb, vs);
      end
      held  = product_8;
      stall = $urandom_range(0, 2);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check("hold_product8", 64'(product_8), 64'(held));
      end
      out_ready_8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready_8 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] corners [10];
      int acc_cnt;
      int hs_cnt;

      vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
      vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
      vecs[2]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
      vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
      vecs[4]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE};
      vecs[5]  = '{32'h00000003, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFFFFFFFFEB};
      vecs[6]  = '{32'h00000000, 32'h12345678, 1'b0, 64'h0000000000000000};
      vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
      vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
      vecs[9]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};
      vecs[10] = '{32'h12345678, 32'h00000002, 1'b0, 64'h000000002468ACF0};
      vecs[11] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
      vecs[12] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};

      corners = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

      // Reset values while reset is held.
      #3;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_product", product, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven 32-bit vectors.
      for (int i = 0; i < 13; i++) begin
         run32(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vexp, 0, 1'b0);
      end

      // Back-pressure for 6 cycles, and inputs wiggled during RUN.
      run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 6, 1'b0);
      run32(32'h00000003, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFFFFFFFFEB, 2, 1'b1);

      // in_valid and out_ready held high: one operation per IDLE visit, period N+2 edges.
      @(negedge clk);
      in_valid  = 1'b1;
      a         = 32'd5;
      b         = 32'd6;
      is_signed = 1'b0;
      out_ready = 1'b1;
      acc_cnt   = 0;
      hs_cnt    = 0;
      for (int i = 0; i < 76; i++) begin
         if (in_ready) acc_cnt++;
         if (out_valid) hs_cnt++;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream_accepts", 64'(acc_cnt), 64'(4));
      check("stream_handoffs", 64'(hs_cnt), 64'(4));
      check("stream_product", product, 64'd30);
      check("stream_idle", 64'(in_ready), 64'(1));

      // Reset during digit 5 discards the operation immediately.
      @(negedge clk);
      in_valid  = 1'b1;
      a         = 32'h12345678;
      b         = 32'h9ABCDEF0;
      is_signed = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_product", product, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run32(32'h00000003, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFFFFFFFFEB, 0, 1'b0);

      // WIDTH=8: corner cross-product in both modes, then random pairs.
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
               run8(corners[i], corners[j], m[0]);
            end
         end
      end
      for (int k = 0; k < 400; k++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
